// File: rtl/ctc_multi_if.sv
// Memory-mapped bus bundle for the CTC: chip select, strobes, address and data.
interface ctc_multi_if #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
);
  logic              cs;
  logic              read_enable;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data_in;
  logic [DATA_W-1:0] read_data_out;

  modport master (
    output cs, read_enable, write_enable, address, write_data_in,
    input  read_data_out
  );

  modport slave (
    input  cs, read_enable, write_enable, address, write_data_in,
    output read_data_out
  );
endinterface

// File: rtl/ctc_multi.sv
// Multi-channel timer/counter: CHANNELS down-counters with active-low terminal pulses and a shared irq.
// Defining CTC_PRESCALE_EN adds a per-channel timer prescaler at reg 2.
module ctc_multi #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = $clog2(CHANNELS) + 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pulse,
  ctc_multi_if.slave          bus,
  output logic [CHANNELS-1:0] ctc_out,
  output logic                irq
);
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [1:0]  REG_MODE = 2'd0;
  localparam logic [1:0]  REG_INIT = 2'd1;
`ifdef CTC_PRESCALE_EN
  localparam logic [1:0]  REG_PRESCALE = 2'd2;
`endif

  typedef logic [DATA_W-1:0] word_t;

  // Address decode and strobe qualification; a read beats a simultaneous write
  logic [CH_W-1:0] sel_ch;
  logic [1:0]      sel_reg;
  logic            sel_valid;
  logic            rd_c;
  logic            wr_c;

  assign sel_reg   = bus.address[1:0];
  assign sel_ch    = CH_W'(bus.address >> 2);
  assign sel_valid = (bus.address >> 2) < ADDR_W'(CHANNELS);
  assign rd_c      = bus.cs & bus.read_enable;
  assign wr_c      = bus.cs & bus.write_enable & ~bus.read_enable;

  // Pulse synchroniser, edge-detect register and registered event
  logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q, evt_q;

  // Per-channel architectural state
  word_t mode_q [CHANNELS];
  word_t mode_d [CHANNELS];
  word_t init_q [CHANNELS];
  word_t init_d [CHANNELS];
  word_t cnt_q  [CHANNELS];
  word_t cnt_d  [CHANNELS];
`ifdef CTC_PRESCALE_EN
  word_t psc_q     [CHANNELS];
  word_t psc_d     [CHANNELS];
  word_t psc_cnt_q [CHANNELS];
  word_t psc_cnt_d [CHANNELS];
`endif
  logic [CHANNELS-1:0] run_q, run_d;
  logic [CHANNELS-1:0] tout_q, tout_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] term_d;
  logic [CHANNELS-1:0] tick_c;
  logic [CHANNELS-1:0] hit_c;
  logic                irq_d;
  word_t               rdata_c;
  word_t               rdata_q;

  // Next-state: bus writes take priority over a tick in the same cycle
  always_comb begin
    irq_d  = 1'b0;
    tick_c = '0;
    hit_c  = '0;
    term_d = '0;
    run_d  = run_q;
    tout_d = tout_q;
    done_d = done_q;
    for (int i = 0; i < CHANNELS; i++) begin
      mode_d[i] = mode_q[i];
      init_d[i] = init_q[i];
      cnt_d[i]  = cnt_q[i];
`ifdef CTC_PRESCALE_EN
      psc_d[i]     = psc_q[i];
      psc_cnt_d[i] = psc_cnt_q[i];
      tick_c[i]    = mode_q[i][0] ? evt_q[i] : (psc_cnt_q[i] >= psc_q[i]);
`else
      tick_c[i]    = mode_q[i][0] ? evt_q[i] : 1'b1;
`endif
      hit_c[i] = sel_valid && (sel_ch == CH_W'(i));

      // STATUS read clears flags; a terminal event below re-sets them
      if (rd_c && hit_c[i] && (sel_reg == REG_MODE)) begin
        tout_d[i] = 1'b0;
        done_d[i] = 1'b0;
      end

      if (wr_c && hit_c[i] && (sel_reg == REG_INIT)) begin
        init_d[i] = bus.write_data_in;
        cnt_d[i]  = bus.write_data_in;
        run_d[i]  = |bus.write_data_in;
`ifdef CTC_PRESCALE_EN
        psc_cnt_d[i] = '0;
`endif
      end else if (wr_c && hit_c[i] && (sel_reg == REG_MODE)) begin
        mode_d[i] = bus.write_data_in;
        run_d[i]  = 1'b0;
      end else begin
`ifdef CTC_PRESCALE_EN
        if (wr_c && hit_c[i] && (sel_reg == REG_PRESCALE))
          psc_d[i] = bus.write_data_in;
        if (run_q[i] && !mode_q[i][0])
          psc_cnt_d[i] = (psc_cnt_q[i] >= psc_q[i]) ? '0 : psc_cnt_q[i] + word_t'(1);
`endif
        if (run_q[i] && tick_c[i]) begin
          if (cnt_q[i] > word_t'(1)) begin
            cnt_d[i] = cnt_q[i] - word_t'(1);
          end else if (cnt_q[i] == word_t'(1)) begin
            term_d[i] = 1'b1;
            if (mode_q[i][0]) done_d[i] = 1'b1;
            else              tout_d[i] = 1'b1;
            if (mode_q[i][1]) begin
              cnt_d[i] = init_q[i];
            end else begin
              cnt_d[i] = '0;
              run_d[i] = 1'b0;
            end
          end
        end
      end

      irq_d = irq_d | (mode_d[i][2] & (tout_d[i] | done_d[i]));
    end
  end

  // Read mux for the addressed channel; unmapped registers read 0
  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (hit_c[i]) begin
        case (sel_reg)
          2'd0: begin
            rdata_c[DATA_W-1] = run_q[i];
            rdata_c[1]        = done_q[i];
            rdata_c[0]        = tout_q[i];
          end
          2'd1: rdata_c = cnt_q[i];
`ifdef CTC_PRESCALE_EN
          2'd2: rdata_c = psc_q[i];
`endif
          default: rdata_c = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      evt_q   <= '0;
      run_q   <= '0;
      tout_q  <= '0;
      done_q  <= '0;
      ctc_out <= '1;
      irq     <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= '0;
        init_q[i] <= '0;
        cnt_q[i]  <= '0;
`ifdef CTC_PRESCALE_EN
        psc_q[i]     <= '0;
        psc_cnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q <= pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      evt_q   <= sync2_q & ~sync3_q;
      run_q   <= run_d;
      tout_q  <= tout_d;
      done_q  <= done_d;
      ctc_out <= ~term_d;
      irq     <= irq_d;
      if (rd_c) rdata_q <= rdata_c;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i] <= mode_d[i];
        init_q[i] <= init_d[i];
        cnt_q[i]  <= cnt_d[i];
`ifdef CTC_PRESCALE_EN
        psc_q[i]     <= psc_d[i];
        psc_cnt_q[i] <= psc_cnt_d[i];
`endif
      end
    end
  end

  assign bus.read_data_out = rdata_q;
endmodule

// File: tb/tb_ctc_multi.sv
// Self-checking bench for ctc_multi: directed scenarios plus randomized timer runs against arithmetic expectations.
module tb_ctc_multi;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [CHANNELS-1:0] pulse = '0;
  logic [CHANNELS-1:0] ctc_out;
  logic                irq;

  int errors = 0;
  int checks = 0;

  ctc_multi_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ctc_multi #(.CHANNELS(CHANNELS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .pulse   (pulse),
    .bus     (bus),
    .ctc_out (ctc_out),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  initial begin
    repeat (50000) @(posedge clock);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [15:0] d);
    bus.cs = 1'b1; bus.write_enable = 1'b1; bus.read_enable = 1'b0;
    bus.address = ADDR_W'((ch << 2) | rg); bus.write_data_in = d;
    idle(1);
    bus.cs = 1'b0; bus.write_enable = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [15:0] d);
    bus.cs = 1'b1; bus.read_enable = 1'b1; bus.write_enable = 1'b0;
    bus.address = ADDR_W'((ch << 2) | rg);
    idle(1);
    d = bus.read_data_out;
    bus.cs = 1'b0; bus.read_enable = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; pulse = '0;
    bus.cs = 1'b0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.address = '0; bus.write_data_in = '0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    do_reset;
    checks++; if (bus.read_data_out !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", bus.read_data_out); end
    checks++; if (ctc_out !== 2'b11) begin errors++; $display("FAIL reset_ctc_out: got %b expected 11", ctc_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int ch = 0; ch < 2; ch++) begin
      bus_read(ch, 0, d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_status ch%0d: got %h expected 0000", ch, d); end
      bus_read(ch, 1, d);
      checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_cnt ch%0d: got %h expected 0000", ch, d); end
    end
  endtask

  task automatic test_timer_oneshot;
    logic [15:0] d;
    do_reset;
    bus_write(0, 0, 16'h0);
    bus_write(0, 1, 16'd5);
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      checks++; if (ctc_out !== ((k == 5) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL oneshot_out k=%0d: got %b expected %b", k, ctc_out, (k == 5) ? 2'b10 : 2'b11); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq k=%0d: got %b expected 0", k, irq); end
    end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL oneshot_status1: got %h expected 0001", d); end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_status2: got %h expected 0000", d); end
    bus_read(0, 1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oneshot_cnt: got %h expected 0000", d); end
  endtask

  task automatic test_timer_repeat;
    logic [15:0] d;
    do_reset;
    bus_write(1, 0, 16'h6);
    bus_write(1, 1, 16'd3);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      checks++; if (ctc_out[1] !== ((k % 3) != 0)) begin errors++; $display("FAIL repeat_out k=%0d: got %b expected %b", k, ctc_out[1], (k % 3) != 0); end
      checks++; if (irq !== (k >= 3)) begin errors++; $display("FAIL repeat_irq k=%0d: got %b expected %b", k, irq, k >= 3); end
    end
    bus_read(1, 0, d);
    checks++; if (d !== 16'h8001) begin errors++; $display("FAIL repeat_status1: got %h expected 8001", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL repeat_irq_drop: got %b expected 0", irq); end
    bus_read(1, 0, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL repeat_status2: got %h expected 8000", d); end
    checks++; if (ctc_out[1] !== 1'b0) begin errors++; $display("FAIL repeat_pulse_during_read: got %b expected 0", ctc_out[1]); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL repeat_irq_reassert: got %b expected 1", irq); end
    bus_read(1, 0, d);
    checks++; if (d !== 16'h8001) begin errors++; $display("FAIL repeat_status_event_wins: got %h expected 8001", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL repeat_irq_clear2: got %b expected 0", irq); end
    bus_write(1, 0, 16'h0);
  endtask

  task automatic pulse_edge(input int ch);
    pulse[ch] = 1'b1;
    idle(2);
    pulse[ch] = 1'b0;
    idle(2);
  endtask

  task automatic test_counter;
    logic [15:0] d;
    do_reset;
    bus_write(0, 0, 16'h1);
    bus_write(0, 1, 16'd4);
    for (int p = 0; p < 3; p++) pulse_edge(0);
    idle(2);
    bus_read(0, 1, d);
    checks++; if (d !== 16'd1) begin errors++; $display("FAIL counter_cnt3: got %h expected 0001", d); end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL counter_status3: got %h expected 8000", d); end
    pulse[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      if (k == 2) pulse[0] = 1'b0;
      checks++; if (ctc_out[0] !== (k != 4)) begin errors++; $display("FAIL counter_out k=%0d: got %b expected %b", k, ctc_out[0], k != 4); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL counter_irq: got %b expected 0", irq); end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL counter_status4: got %h expected 0002", d); end
    bus_read(0, 1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL counter_cnt4: got %h expected 0000", d); end
  endtask

  task automatic test_collision;
    logic [15:0] d;
    do_reset;
    bus_write(0, 0, 16'h0);
    bus_write(0, 1, 16'd3);
    idle(2);
    bus_write(0, 1, 16'd9);
    checks++; if (ctc_out[0] !== 1'b1) begin errors++; $display("FAIL collide_no_pulse: got %b expected 1", ctc_out[0]); end
    bus_read(0, 1, d);
    checks++; if (d !== 16'd9) begin errors++; $display("FAIL collide_cnt: got %h expected 0009", d); end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL collide_status: got %h expected 8000", d); end
    bus_write(0, 0, 16'h0);
  endtask

  task automatic test_bus_rules;
    logic [15:0] d;
    do_reset;
    bus_write(1, 0, 16'h0);
    bus_write(1, 1, 16'h55);
    bus_read(1, 1, d);
    checks++; if (d !== 16'h55) begin errors++; $display("FAIL bus_cnt_read: got %h expected 0055", d); end
    bus.cs = 1'b0; bus.read_enable = 1'b1; bus.address = ADDR_W'(1);
    idle(1);
    bus.read_enable = 1'b0;
    checks++; if (bus.read_data_out !== 16'h55) begin errors++; $display("FAIL bus_cs_read_hold: got %h expected 0055", bus.read_data_out); end
    bus.cs = 1'b0; bus.write_enable = 1'b1; bus.address = ADDR_W'(1); bus.write_data_in = 16'd20;
    idle(1);
    bus.write_enable = 1'b0;
    bus_read(0, 0, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL bus_cs_write_ignored: got %h expected 0000", d); end
    bus.cs = 1'b1; bus.read_enable = 1'b1; bus.write_enable = 1'b1;
    bus.address = ADDR_W'(1); bus.write_data_in = 16'd7;
    idle(1);
    bus.cs = 1'b0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    checks++; if (bus.read_data_out !== 16'h0) begin errors++; $display("FAIL bus_rw_read: got %h expected 0000", bus.read_data_out); end
    bus_read(0, 1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL bus_rw_write_ignored: got %h expected 0000", d); end
    bus_write(0, 3, 16'hFFFF);
    bus_read(0, 3, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL bus_reg3: got %h expected 0000", d); end
    bus_write(1, 0, 16'h0);
  endtask

  task automatic test_reg2;
    logic [15:0] d;
    do_reset;
`ifdef CTC_PRESCALE_EN
    bus_write(0, 2, 16'd2);
    bus_write(0, 0, 16'h0);
    bus_write(0, 1, 16'd2);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      checks++; if (ctc_out[0] !== (k != 6)) begin errors++; $display("FAIL prescale_out k=%0d: got %b expected %b", k, ctc_out[0], k != 6); end
    end
    bus_read(0, 2, d);
    checks++; if (d !== 16'd2) begin errors++; $display("FAIL prescale_read: got %h expected 0002", d); end
`else
    bus_write(0, 2, 16'h1234);
    bus_read(0, 2, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL reg2_read: got %h expected 0000", d); end
`endif
  endtask

  task automatic test_reset_midcount;
    logic [15:0] d;
    do_reset;
    bus_write(1, 0, 16'h0);
    bus_write(0, 0, 16'h6);
    bus_write(0, 1, 16'd10);
    bus_write(1, 1, 16'd3);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++; if (ctc_out !== 2'b11) begin errors++; $display("FAIL midreset_out: got %b expected 11", ctc_out); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    checks++; if (bus.read_data_out !== 16'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0000", bus.read_data_out); end
    bus_read(0, 1, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL midreset_cnt: got %h expected 0000", d); end
    bus_read(0, 0, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL midreset_status0: got %h expected 0000", d); end
    bus_read(1, 0, d);
    checks++; if (d !== 16'h0) begin errors++; $display("FAIL midreset_status1: got %h expected 0000", d); end
    idle(12);
    checks++; if (ctc_out !== 2'b11) begin errors++; $display("FAIL midreset_idle_out: got %b expected 11", ctc_out); end
  endtask

  // Random timer runs; expectations come from the down-count arithmetic
  task automatic test_random;
    logic [15:0] d;
    int ch, n, rep, ie, len, exp_cnt;
    bit exp_low;
    for (int it = 0; it < 10; it++) begin
      do_reset;
      ch  = int'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 12));
      rep = int'($urandom_range(0, 1));
      ie  = int'($urandom_range(0, 1));
      len = int'($urandom_range(n + 1, 3 * n + 2));
      bus_write(ch, 0, 16'(ie * 4 + rep * 2));
      bus_write(ch, 1, 16'(n));
      for (int k = 1; k <= len; k++) begin
        pulse = 2'($urandom);
        idle(1);
        exp_low = (rep != 0) ? ((k % n) == 0) : (k == n);
        checks++; if (ctc_out[ch] !== !exp_low) begin errors++; $display("FAIL rand_out it=%0d ch=%0d n=%0d k=%0d: got %b expected %b", it, ch, n, k, ctc_out[ch], !exp_low); end
        checks++; if (ctc_out[1 - ch] !== 1'b1) begin errors++; $display("FAIL rand_other it=%0d k=%0d: got %b expected 1", it, k, ctc_out[1 - ch]); end
        checks++; if (irq !== ((ie != 0) && (k >= n))) begin errors++; $display("FAIL rand_irq it=%0d k=%0d: got %b expected %b", it, k, irq, (ie != 0) && (k >= n)); end
      end
      pulse = '0;
      exp_cnt = (rep != 0) ? (n - (len % n)) : 0;
      bus_read(ch, 1, d);
      checks++; if (d !== 16'(exp_cnt)) begin errors++; $display("FAIL rand_cnt it=%0d n=%0d len=%0d: got %h expected %h", it, n, len, d, 16'(exp_cnt)); end
      bus_read(ch, 0, d);
      checks++; if (d !== ((rep != 0) ? 16'h8001 : 16'h0001)) begin errors++; $display("FAIL rand_status it=%0d: got %h expected %h", it, d, (rep != 0) ? 16'h8001 : 16'h0001); end
    end
  endtask

  initial begin
    bus.cs = 1'b0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.address = '0; bus.write_data_in = '0;
    test_reset;
    test_timer_oneshot;
    test_timer_repeat;
    test_counter;
    test_collision;
    test_bus_rules;
    test_reg2;
    test_reset_midcount;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
